// File: rtl/shift_arb_ctrl.sv
// Round-robin arbiter and LOAD/SHIFT/CAPT sequencer driving one registered 8-bit shifter.
// Optional macro XACT_CNT_EN adds per-requester 16-bit completion counters cnt0/cnt1.
module shift_arb_ctrl #(
    parameter int DW = 8,
    parameter int SW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [1:0]    op0,
    input  logic [SW-1:0] amt0,
    input  logic [DW-1:0] din0,
    input  logic          req1,
    input  logic [1:0]    op1,
    input  logic [SW-1:0] amt1,
    input  logic [DW-1:0] din1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic          err,
    output logic [DW-1:0] result,
    output logic          busy,
    output logic [1:0]    sh_c,
    output logic [SW-1:0] sh_s,
    output logic [DW-1:0] sh_i,
    input  logic [DW-1:0] sh_o
`ifdef XACT_CNT_EN
    ,
    output logic [15:0]   cnt0,
    output logic [15:0]   cnt1
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, CAPT} state_e;

    state_e        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [SW-1:0] amt_q, amt_d;
    logic [DW-1:0] din_q, din_d;
    logic          last_q, last_d;
    logic          win_q, win_d;
    logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic          done0_q, done0_d, done1_q, done1_d;
    logic          err_q, err_d;
    logic [DW-1:0] result_q, result_d;
    logic          sel1;
    logic [1:0]    sel_op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            amt_q    <= '0;
            din_q    <= '0;
            last_q   <= 1'b1;
            win_q    <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            amt_q    <= amt_d;
            din_q    <= din_d;
            last_q   <= last_d;
            win_q    <= win_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        // Requester 1 wins if alone, or on a tie when requester 0 was served last.
        sel1     = req1 && (!req0 || !last_q);
        sel_op   = sel1 ? op1 : op0;
        state_d  = state_q;
        op_d     = op_q;
        amt_d    = amt_q;
        din_d    = din_q;
        last_d   = last_q;
        win_d    = win_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        err_d    = err_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    op_d    = sel_op;
                    amt_d   = sel1 ? amt1 : amt0;
                    din_d   = sel1 ? din1 : din0;
                    last_d  = sel1;
                    win_d   = sel1;
                    gnt0_d  = !sel1;
                    gnt1_d  = sel1;
                    state_d = (sel_op == 2'b11) ? CAPT : LOAD;
                end
            end
            LOAD: begin
                state_d = ((op_q == 2'b01 || op_q == 2'b10) && amt_q != '0) ? SHIFT : CAPT;
            end
            SHIFT: state_d = CAPT;
            CAPT: begin
                if (op_q != 2'b11) begin
                    result_d = sh_o;
                    err_d    = 1'b0;
                end else begin
                    err_d    = 1'b1;
                end
                done0_d = !win_q;
                done1_d = win_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sh_c = 2'b00;
        case (state_q)
            LOAD:    sh_c = 2'b11;
            SHIFT:   sh_c = op_q;
            default: sh_c = 2'b00;
        endcase
    end

    assign sh_s   = amt_q;
    assign sh_i   = din_q;
    assign gnt0   = gnt0_q;
    assign gnt1   = gnt1_q;
    assign done0  = done0_q;
    assign done1  = done1_q;
    assign err    = err_q;
    assign result = result_q;
    assign busy   = (state_q != IDLE);

`ifdef XACT_CNT_EN
    logic [15:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (state_q == CAPT) begin
            if (win_q) cnt1_q <= cnt1_q + 16'd1;
            else       cnt0_q <= cnt0_q + 16'd1;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_shift_arb_ctrl.sv
// Bench for shift_arb_ctrl: directed plan steps plus randomized traffic against a transaction-level model.
// Counter checks are compiled in when XACT_CNT_EN is defined.
module tb_shift_arb_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [1:0] op0, op1;
  logic [2:0] amt0, amt1;
  logic [7:0] din0, din1;
  logic       gnt0, gnt1, done0, done1, err, busy;
  logic [7:0] result;
  logic [1:0] sh_c;
  logic [2:0] sh_s;
  logic [7:0] sh_i;
  logic [7:0] sh_o = '0;
`ifdef XACT_CNT_EN
  logic [15:0] cnt0, cnt1;
  logic [15:0] m_cnt0 = '0;
  logic [15:0] m_cnt1 = '0;
`endif

  int         n_checks = 0;
  int         n_errors = 0;
  int         m_last = 1;
  logic [7:0] m_result = '0;
  logic [7:0] exp_q[$];
  logic [1:0] mask;
  bit         saw_done;

  shift_arb_ctrl #(.DW(8), .SW(3)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .amt0(amt0), .din0(din0),
    .req1(req1), .op1(op1), .amt1(amt1), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err(err), .result(result), .busy(busy),
    .sh_c(sh_c), .sh_s(sh_s), .sh_i(sh_i), .sh_o(sh_o)
`ifdef XACT_CNT_EN
    , .cnt0(cnt0), .cnt1(cnt1)
`endif
  );

  always #5 clk = ~clk;

  // Registered shifter the controller drives.
  always @(posedge clk) begin
    case (sh_c)
      2'b01:   sh_o <= sh_o << sh_s;
      2'b10:   sh_o <= sh_o >> sh_s;
      2'b11:   sh_o <= sh_i;
      default: sh_o <= sh_o;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one transaction starting in an IDLE cycle with at least one req high; returns in its done cycle.
  task automatic serve();
    int         w;
    int         lat;
    int         cyc;
    logic [1:0] op;
    logic [2:0] amt;
    logic [7:0] din;
    logic [7:0] seq;
    logic [7:0] exp_seq;
    logic       exp_err;
    bit         seen;
    if (req0 && req1) w = (m_last == 0) ? 1 : 0;
    else              w = req1 ? 1 : 0;
    m_last = w;
    op  = (w == 1) ? op1  : op0;
    amt = (w == 1) ? amt1 : amt0;
    din = (w == 1) ? din1 : din0;
    exp_err = (op == 2'b11);
    if (op == 2'b11) begin
      lat = 2; exp_seq = 8'h00;
    end else if (op != 2'b00 && amt != 3'd0) begin
      lat = 4; exp_seq = {2'b00, 2'b11, op, 2'b00};
    end else begin
      lat = 3; exp_seq = 8'b0000_1100;
    end
    if (op == 2'b01)      m_result = din << amt;
    else if (op == 2'b10) m_result = din >> amt;
    else if (op == 2'b00) m_result = din;
    exp_q.push_back(m_result);

    @(posedge clk); #1;
    cyc = 1;
    check("gnt", 32'({gnt1, gnt0}), (w == 1) ? 32'h2 : 32'h1);
    check("busy_after_gnt", 32'(busy), 32'h1);
    if (w == 1) req1 = 1'b0; else req0 = 1'b0;
    seq  = '0;
    seen = 0;
    while (!seen && cyc < 8) begin
      if (((w == 1) ? done1 : done0) === 1'b1) seen = 1;
      else begin
        seq = {seq[5:0], sh_c};
        @(posedge clk); #1;
        cyc++;
      end
    end
    check("done_seen", 32'(seen), 32'h1);
    check("latency", 32'(cyc), 32'(lat));
    check("sh_c_seq", 32'(seq), 32'(exp_seq));
    check("result", 32'(result), 32'(exp_q.pop_front()));
    check("err", 32'(err), 32'(exp_err));
    check("other_done", 32'((w == 1) ? done0 : done1), 32'h0);
    check("gnt_clear", 32'({gnt1, gnt0}), 32'h0);
    check("busy_done", 32'(busy), 32'h0);
`ifdef XACT_CNT_EN
    if (w == 1) m_cnt1 = m_cnt1 + 16'd1; else m_cnt0 = m_cnt0 + 16'd1;
    check("cnt0", 32'(cnt0), 32'(m_cnt0));
    check("cnt1", 32'(cnt1), 32'(m_cnt1));
`endif
  endtask

  task automatic set0(input logic [1:0] op, input logic [2:0] amt, input logic [7:0] din);
    req0 = 1'b1; op0 = op; amt0 = amt; din0 = din;
  endtask

  task automatic set1(input logic [1:0] op, input logic [2:0] amt, input logic [7:0] din);
    req1 = 1'b1; op1 = op; amt1 = amt; din1 = din;
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; op0 = '0; amt0 = '0; din0 = '0;
    req1 = 1'b0; op1 = '0; amt1 = '0; din1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", 32'({gnt0, gnt1, done0, done1, err, busy}), 32'h0);
    check("rst_result", 32'(result), 32'h0);
    check("rst_sh_c", 32'(sh_c), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Shift left: 0F << 3, full four-cycle path.
    set0(2'b01, 3'd3, 8'h0F);
    serve();
    // Shift right by zero skips SHIFT; issued back-to-back in the done cycle.
    set1(2'b10, 3'd0, 8'hA5);
    serve();

    // Tie sequence: grants must alternate 0,1,0,1.
    set0(2'b01, 3'd2, 8'h33);
    set1(2'b10, 3'd7, 8'h80);
    serve();
    set0(2'b01, 3'd7, 8'hFF);
    serve();
    set1(2'b00, 3'd5, 8'h5A);
    serve();
    serve();

    // Illegal opcode: error, result retained.
    set0(2'b11, 3'd2, 8'h12);
    serve();

    // Reset asserted while SHIFT is active.
    set0(2'b01, 3'd5, 8'h0F);
    @(posedge clk); #1;
    req0 = 1'b0;
    @(posedge clk); #1;
    check("shift_cycle_sh_c", 32'(sh_c), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_outs", 32'({gnt0, gnt1, done0, done1, err, busy}), 32'h0);
    check("async_rst_result", 32'(result), 32'h0);
    check("async_rst_sh_c", 32'(sh_c), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_last = 1;
    m_result = '0;
`ifdef XACT_CNT_EN
    m_cnt0 = '0;
    m_cnt1 = '0;
`endif
    saw_done = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done0 || done1) saw_done = 1;
    end
    check("no_done_after_rst", 32'(saw_done), 32'h0);
    set1(2'b00, 3'd0, 8'h3C);
    serve();

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      if (!req0 && !req1) begin
        if ($urandom_range(0, 2) == 0) begin
          @(posedge clk); #1;
        end
        mask = 2'($urandom_range(1, 3));
        if (mask[0]) set0(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
        if (mask[1]) set1(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      end
      serve();
    end
    if (req0 || req1) serve();

`ifdef XACT_CNT_EN
    @(posedge clk); #1;
    force dut.cnt0_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.cnt0_q;
    m_cnt0 = 16'hFFFF;
    set0(2'b00, 3'd0, 8'h11);
    serve();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
